// File: rtl/qqspi_rcache_if.sv
// rtl/qqspi_rcache_if.sv - valid/ready word bus used on both sides of the read cache
interface qqspi_rcache_if;
    logic        valid;
    logic        ready;
    logic [22:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (output valid, output addr, output wdata, output wstrb,
                    input  ready, input  rdata);
    modport slave  (input  valid, input  addr, input  wdata, input  wstrb,
                    output ready, output rdata);
endinterface

// File: rtl/qqspi_rcache.sv
// rtl/qqspi_rcache.sv - direct-mapped write-through word cache in front of the qqspi controller
module qqspi_rcache #(
    parameter int INDEX_BITS = 6,
    parameter bit CACHE_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    qqspi_rcache_if.slave   cpu,
    qqspi_rcache_if.master  mem
);
    localparam int NLINES = 1 << INDEX_BITS;
    localparam int TAG_W  = 23 - INDEX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_DONE, S_RELEASE} state_t;

    state_t              r_state;
    logic [NLINES-1:0]   r_valid;
    logic                r_flush_pend;
    logic                r_cpu_ready;
    logic [31:0]         r_cpu_rdata;
    logic                r_mem_valid;
    logic [22:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_wstrb;
    logic [TAG_W-1:0]    r_tag  [NLINES];
    logic [31:0]         r_data [NLINES];

    logic [INDEX_BITS-1:0] w_req_idx, w_cap_idx;
    logic [TAG_W-1:0]      w_req_tag, w_cap_tag;
    logic                  w_req_hit, w_cap_hit, w_strb_ok;
    logic                  w_fill_we, w_merge_we;
    logic [31:0]           w_merged;

    assign w_req_idx = cpu.addr[INDEX_BITS-1:0];
    assign w_req_tag = cpu.addr[22:INDEX_BITS];
    assign w_req_hit = CACHE_EN && r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

    // Once a request is forwarded, the captured mem address is the request address.
    assign w_cap_idx = r_mem_addr[INDEX_BITS-1:0];
    assign w_cap_tag = r_mem_addr[22:INDEX_BITS];
    assign w_cap_hit = CACHE_EN && r_valid[w_cap_idx] && (r_tag[w_cap_idx] == w_cap_tag);

    always_comb begin
        w_strb_ok = 1'b0;
        case (r_mem_wstrb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_strb_ok = 1'b1;
            default:                   w_strb_ok = 1'b0;
        endcase
        w_merged = r_data[w_cap_idx];
        for (int b = 0; b < 4; b++) begin
            if (r_mem_wstrb[b]) w_merged[8*b +: 8] = r_mem_wdata[8*b +: 8];
        end
    end

    assign w_fill_we  = (r_state == S_FILL)  && mem.ready && CACHE_EN;
    assign w_merge_we = (r_state == S_WRITE) && mem.ready && w_cap_hit && w_strb_ok;

    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_cap_idx]  <= w_cap_tag;
            r_data[w_cap_idx] <= mem.rdata;
        end else if (w_merge_we) begin
            r_data[w_cap_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_cpu_ready  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
        end else begin
            if (flush && (r_state != S_IDLE)) r_flush_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_flush_pend || flush) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (cpu.valid) begin
                        if (cpu.wstrb == 4'b0000) begin
                            if (w_req_hit) begin
                                r_cpu_rdata <= r_data[w_req_idx];
                                r_cpu_ready <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_mem_valid <= 1'b1;
                                r_mem_addr  <= cpu.addr;
                                r_mem_wstrb <= 4'b0000;
                                r_state     <= S_FILL;
                            end
                        end else begin
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= cpu.addr;
                            r_mem_wdata <= cpu.wdata;
                            r_mem_wstrb <= cpu.wstrb;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_FILL: begin
                    if (mem.ready) begin
                        r_mem_valid <= 1'b0;
                        r_cpu_rdata <= mem.rdata;
                        r_cpu_ready <= 1'b1;
                        if (CACHE_EN) r_valid[w_cap_idx] <= 1'b1;
                        r_state     <= S_RELEASE;
                    end
                end
                S_WRITE: begin
                    if (mem.ready) begin
                        r_mem_valid <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        // Odd strobes become full-word writes downstream, so the line is stale.
                        if (w_cap_hit && !w_strb_ok) r_valid[w_cap_idx] <= 1'b0;
                        r_state     <= S_RELEASE;
                    end
                end
                S_DONE: begin
                    r_cpu_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
                S_RELEASE: begin
                    r_cpu_ready <= 1'b0;
                    if (!mem.ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu.ready = r_cpu_ready;
    assign cpu.rdata = r_cpu_rdata;
    assign mem.valid = r_mem_valid;
    assign mem.addr  = r_mem_addr;
    assign mem.wdata = r_mem_wdata;
    assign mem.wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_qqspi_rcache.sv
// tb/tb_qqspi_rcache.sv - bench for qqspi_rcache with a qqspi memory model and reference cache
module tb_qqspi_rcache;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic flush;
    qqspi_rcache_if cpu_if ();
    qqspi_rcache_if mem_if ();

    qqspi_rcache #(.INDEX_BITS(6), .CACHE_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .cpu   (cpu_if),
        .mem   (mem_if)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          lat = 4;
    int          cnt = 0;
    int          proto_viol = 0;
    bit          prev_mvalid = 1'b0;
    logic [22:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] mem_model [int];
    bit          ref_valid [64];
    logic [16:0] ref_tag   [64];

    typedef struct {
        bit          wr;
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rd;
        bit          exp_miss;
        int          lat;
    } vec_t;
    vec_t tbl [13];

    function automatic bit strb_supported(input logic [3:0] s);
        return s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [22:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return {9'h15, a} ^ 32'h5A5A_0000;
    endfunction

    function automatic void mem_wr(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = mem_rd(a);
        if (strb_supported(s)) begin
            for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        end else begin
            cur = d;
        end
        mem_model[int'(a)] = cur;
    endfunction

    function automatic bit ref_hit(input logic [22:0] a);
        return ref_valid[a[5:0]] && (ref_tag[a[5:0]] == a[22:6]);
    endfunction

    function automatic void ref_update(input bit wr, input logic [22:0] a, input logic [3:0] s);
        if (!wr) begin
            ref_valid[a[5:0]] = 1'b1;
            ref_tag[a[5:0]]   = a[22:6];
        end else if (ref_hit(a) && !strb_supported(s)) begin
            ref_valid[a[5:0]] = 1'b0;
        end
    endfunction

    function automatic void ref_flush();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // qqspi model: fixed latency, ready held until valid drops
    initial begin
        mem_if.ready = 1'b0;
        mem_if.rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_if.valid && mem_if.ready && !prev_mvalid) proto_viol++;
            prev_mvalid = mem_if.valid;
            if (reset) begin
                mem_if.ready = 1'b0;
                cnt = 0;
            end else if (mem_if.ready) begin
                if (!mem_if.valid) mem_if.ready = 1'b0;
            end else if (mem_if.valid) begin
                if (cnt >= lat) begin
                    last_addr  = mem_if.addr;
                    last_wdata = mem_if.wdata;
                    last_wstrb = mem_if.wstrb;
                    if (mem_if.wstrb != 4'b0000) mem_wr(mem_if.addr, mem_if.wdata, mem_if.wstrb);
                    else mem_if.rdata = mem_rd(mem_if.addr);
                    mem_if.ready = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic do_access(input bit wr, input logic [22:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd, output bit missed,
                             output int cyc);
        missed = 1'b0;
        cyc    = 0;
        rd     = '0;
        @(negedge clk);
        cpu_if.valid = 1'b1;
        cpu_if.addr  = a;
        cpu_if.wdata = d;
        cpu_if.wstrb = wr ? s : 4'b0000;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (mem_if.valid) missed = 1'b1;
            if (cpu_if.ready) begin
                cyc = i;
                rd  = cpu_if.rdata;
                break;
            end
        end
        cpu_if.valid = 1'b0;
        if (cyc == 0) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            check("ready_single_pulse", {31'd0, cpu_if.ready}, 32'd0);
        end
    endtask

    task automatic run_check(input bit wr, input logic [22:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_miss);
        logic [31:0] rd;
        bit          missed;
        int          cyc;
        do_access(wr, a, d, s, rd, missed, cyc);
        if (wr) begin
            check("write_forwarded", {31'd0, missed}, 32'd1);
            check("write_fwd_addr",  {9'd0, last_addr}, {9'd0, a});
            check("write_fwd_data",  last_wdata, d);
            check("write_fwd_strb",  {28'd0, last_wstrb}, {28'd0, s});
        end else begin
            check("read_data", rd, exp_rd);
            check("read_miss", {31'd0, missed}, {31'd0, exp_miss});
            if (exp_miss) check("fill_strb_zero", {28'd0, last_wstrb}, 32'd0);
            else          check("hit_latency", cyc, 32'd1);
        end
        ref_update(wr, a, s);
    endtask

    task automatic ref_access(input bit wr, input logic [22:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        run_check(wr, a, d, s, mem_rd(a), wr ? 1'b1 : !ref_hit(a));
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        cpu_if.valid = 1'b0;
        cpu_if.addr  = '0;
        cpu_if.wdata = '0;
        cpu_if.wstrb = '0;
        ref_flush();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", {31'd0, cpu_if.ready}, 32'd0);
        check("rst_cpu_rdata", cpu_if.rdata, 32'd0);
        check("rst_mem_valid", {31'd0, mem_if.valid}, 32'd0);
        check("rst_mem_addr",  {9'd0, mem_if.addr}, 32'd0);
        check("rst_mem_wdata", mem_if.wdata, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_if.wstrb}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        mem_model[32'h40] = 32'hDEADBEEF;
        mem_model[32'h80] = 32'hCAFEF00D;
        tbl[0]  = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b1, 40};
        tbl[1]  = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 3};
        tbl[2]  = '{1'b0, 23'h80, 32'h0,        4'b0000, 32'hCAFEF00D, 1'b1, 5};
        tbl[3]  = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b1, 2};
        tbl[4]  = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 2};
        tbl[5]  = '{1'b1, 23'h40, 32'h11223344, 4'b0010, 32'h0,        1'b1, 6};
        tbl[6]  = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'hDEAD33EF, 1'b0, 2};
        tbl[7]  = '{1'b1, 23'h40, 32'h11223344, 4'b0110, 32'h0,        1'b1, 3};
        tbl[8]  = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'h11223344, 1'b1, 4};
        tbl[9]  = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'h11223344, 1'b0, 4};
        tbl[10] = '{1'b1, 23'h80, 32'hAABBCCDD, 4'b1111, 32'h0,        1'b1, 2};
        tbl[11] = '{1'b0, 23'h80, 32'h0,        4'b0000, 32'hAABBCCDD, 1'b1, 2};
        tbl[12] = '{1'b0, 23'h40, 32'h0,        4'b0000, 32'h11223344, 1'b1, 2};
        for (int i = 0; i < 13; i++) begin
            lat = tbl[i].lat;
            run_check(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb,
                      tbl[i].exp_rd, tbl[i].exp_miss);
        end

        // flush raised mid-fill: data still returned, line dropped afterwards
        mem_model[32'h100] = 32'h0BADF00D;
        lat = 20;
        fork
            run_check(1'b0, 23'h100, 32'h0, 4'b0000, 32'h0BADF00D, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #2 flush = 1'b1;
                @(posedge clk);
                #2 flush = 1'b0;
            end
        join
        ref_flush();
        lat = 3;
        ref_access(1'b0, 23'h100, 32'h0, 4'b0000);
        ref_access(1'b0, 23'h100, 32'h0, 4'b0000);

        // flush together with a request that would hit: flush wins
        ref_flush();
        fork
            ref_access(1'b0, 23'h100, 32'h0, 4'b0000);
            begin
                @(negedge clk);
                flush = 1'b1;
                @(posedge clk);
                #2 flush = 1'b0;
            end
        join

        for (int i = 0; i < 80; i++) begin
            logic [22:0] a;
            a   = 23'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            lat = $urandom_range(1, 6);
            if ($urandom_range(0, 9) < 4)
                ref_access(1'b1, a, $urandom, 4'($urandom_range(1, 15)));
            else
                ref_access(1'b0, a, 32'h0, 4'b0000);
        end

        // reset while a write is in flight
        lat = 30;
        @(negedge clk);
        cpu_if.valid = 1'b1;
        cpu_if.addr  = 23'h200;
        cpu_if.wdata = 32'h01020304;
        cpu_if.wstrb = 4'b1111;
        repeat (4) @(posedge clk);
        #1;
        check("write_inflight", {31'd0, mem_if.valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_mem_valid", {31'd0, mem_if.valid}, 32'd0);
        check("rst_mid_cpu_ready", {31'd0, cpu_if.ready}, 32'd0);
        cpu_if.valid = 1'b0;
        cpu_if.wstrb = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_flush();
        lat = 2;
        for (int i = 0; i < 8; i++) ref_access(1'b0, 23'(i), 32'h0, 4'b0000);
        ref_access(1'b0, 23'h40, 32'h0, 4'b0000);
        ref_access(1'b0, 23'h200, 32'h0, 4'b0000);

        check("mem_valid_reassert", proto_viol, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/qqspi_rcache.md
Name: qqspi_rcache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the CPU data/instruction bus and the qqspi PSRAM/flash controller.
- Read hits are served locally; misses and all writes are forwarded downstream using the same valid/ready/addr/wdata/wstrb protocol the controller accepts.
- Hides the multi-dozen-cycle serial access latency for repeated reads.

Parameters:
- INDEX_BITS, 6: line index width; 2^INDEX_BITS one-word lines; tag width = 23 - INDEX_BITS.
- CACHE_EN, 1: when 0, every access is a miss, nothing is allocated, and the block acts as a pass-through.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_valid  in  1  request valid; held until cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- cpu_addr  in  23  word address (8Mx32)
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte strobes; 0 = read
- cpu_rdata  out  32  read data, valid while cpu_ready = 1
- flush  in  1  pulse; invalidates all lines
- mem_valid  out  1  request to qqspi
- mem_ready  in  1  qqspi ready; stays high until mem_valid drops
- mem_addr  out  23  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_wstrb  out  4  forwarded strobes; 0 for fills
- mem_rdata  in  32  qqspi read data

Behaviour:
- Reset (async): state IDLE; all valid bits 0; cpu_ready, mem_valid = 0; cpu_rdata, mem_addr, mem_wdata, mem_wstrb = 0; flush_pend = 0. Tag and data arrays are not reset.
- All outputs are registered. Index = cpu_addr[INDEX_BITS-1:0]. Tag = cpu_addr[22:INDEX_BITS]. Hit = valid[idx] && tag match && CACHE_EN.
- States: IDLE, FILL, WRITE, DONE, RELEASE.
- IDLE:
  - If flush_pend or flush: clear all valid bits, clear flush_pend, and accept no request this cycle.
  - Else if cpu_valid, read, hit: cpu_rdata <= line; cpu_ready <= 1; go to DONE. Latency: ready is high in the cycle after valid is first seen.
  - Else if cpu_valid, read, miss: drive mem_valid = 1, mem_addr = cpu_addr, mem_wstrb = 0; go to FILL.
  - Else if cpu_valid, write: drive mem_valid = 1 with cpu_addr, cpu_wdata, cpu_wstrb; go to WRITE.
- FILL, on mem_ready:
  - mem_valid <= 0; cpu_rdata <= mem_rdata; cpu_ready <= 1.
  - If CACHE_EN: line <= mem_rdata, tag written, valid set.
  - Go to RELEASE.
- WRITE, on mem_ready:
  - mem_valid <= 0; cpu_ready <= 1; go to RELEASE.
  - On a hit with a supported strobe (0001, 0010, 0100, 1000, 0011, 1100, 1111): merge the strobed bytes into the line.
  - On a hit with any other non-zero strobe: clear valid[idx], because qqspi writes the full word for such strobes.
  - On a miss: no change (no allocate).
- DONE: cpu_ready <= 0; cpu_valid is ignored this cycle; go to IDLE.
- RELEASE: cpu_ready <= 0; stay until mem_ready = 0; cpu_valid is ignored; then go to IDLE.
- Handshake rules:
  - cpu_ready is high for exactly one cycle per request.
  - The master must drop cpu_valid or change the request in the cycle after cpu_ready.
  - mem_valid is never reasserted while mem_ready = 1.
- Flush outside IDLE sets flush_pend; it is applied on the next IDLE cycle. It never aborts an in-flight transfer, and the filled line is then invalidated by the pending flush.
- Flush and a request together in IDLE: flush wins; the request is taken one cycle later.
- cpu_addr/cpu_wdata/cpu_wstrb are captured at acceptance. Changes while busy are ignored.
- Reset mid-transfer: mem_valid drops immediately. The downstream controller is reset by the same system reset.

Test Plan:
- Cold read 0x000040, qqspi returns 0xDEADBEEF after 40 cycles -> one mem request with wstrb = 0; cpu_rdata = 0xDEADBEEF with a single cpu_ready pulse; cpu_ready only after mem_ready drops is not required, but the next request is not issued until it drops.
- Repeat read 0x000040 -> no mem_valid; cpu_ready in the cycle after cpu_valid; data 0xDEADBEEF.
- Alias read 0x000080 (INDEX_BITS = 6, same index, different tag) -> miss and refill; a later read of 0x000040 also misses.
- Write 0x000040, wdata 0x11223344, wstrb 0010 -> forwarded unchanged; next read hits with 0xDEAD33EF. Write with wstrb 0110 -> line invalidated; next read misses.
- Flush pulse asserted during FILL of 0x000100 -> fill completes with correct data; the subsequent read of 0x000100 misses.
- Assert reset during WRITE -> mem_valid = 0 and cpu_ready = 0 immediately; all reads after reset miss.
